fetch_queue: RTL

- Parametrised instruction-fetch front end that replaces the combinational imem port with a request/response memory of variable latency.
- Issues sequential word fetches from a PC register and buffers responses in an in-order FIFO of DEPTH entries.
- Hands {pc, inst, trap} to decode over a valid/ready handshake.
- Supports redirects from execute (taken branch/jump): flushes the buffer and discards in-flight responses.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_sync_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int ILEN = 32;

  // Also used by hart halt detection.
  localparam logic [ILEN-1:0] EBREAK = 32'h00100073;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            trap;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// In-order FIFO with synchronous flush; storage is not reset, only the pointers and count are.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= bump(wr_q);
      if (pop_i)  rd_q <= bump(rd_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches to a variable-latency memory,
// buffers in-order responses, and handles redirects by flushing and dropping in-flight data.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_imem_req,
  output logic [31:0]                o_imem_addr,
  input  logic                       i_imem_ready,
  input  logic                       i_imem_valid,
  input  logic [31:0]                i_imem_rdata,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_inst,
  output logic [31:0]                o_pc,
  output logic                       o_trap,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int SW = CW + 1;

  logic [ILEN-1:0] pc_q, pc_d, trap_pc_q, trap_pc_d;
  logic [OW-1:0]   out_q, out_d, drop_q, drop_d;
  logic            halted_q, halted_d, trap_pend_q, trap_pend_d;

  fetch_entry_t    head, push_entry;
  logic [CW-1:0]   count;
  logic            empty;
  logic [ILEN-1:0] tag_pc;
  logic            unused_tag_empty;
  logic [OW-1:0]   unused_tag_count;

  logic [SW-1:0]   credit;
  logic            req, accept, resp_v, keep, push, valid, pop, tag_pop;

  always_comb begin
    credit = SW'(count) + SW'(out_q);
    // Counting queued entries plus in-flight requests guarantees every response a slot.
    req    = !halted_q && !i_redirect && (out_q < OW'(MAX_OUTSTANDING)) && (credit < SW'(DEPTH));
    accept = req && i_imem_ready;
    resp_v = i_imem_valid && (out_q != '0);
    keep   = resp_v && (drop_q == '0) && !i_redirect;
    // A pending trap never coincides with a kept response: every response still owed is dropped.
    push   = keep || (trap_pend_q && !i_redirect);
    valid  = !empty && !i_redirect;
    pop    = valid && i_ready;
    tag_pop = resp_v && (drop_q == '0);

    push_entry.pc   = trap_pend_q ? trap_pc_q : tag_pc;
    push_entry.inst = trap_pend_q ? '0 : i_imem_rdata;
    push_entry.trap = trap_pend_q;
  end

  always_comb begin
    pc_d        = pc_q;
    out_d       = out_q;
    drop_d      = drop_q;
    halted_d    = halted_q;
    trap_pend_d = 1'b0;
    trap_pc_d   = trap_pc_q;
    if (accept) pc_d = pc_q + 32'd4;
    case ({accept, resp_v})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    if (resp_v && (drop_q != '0)) drop_d = drop_q - OW'(1);
    if (i_redirect) begin
      // Everything still owed after this cycle's response is stale.
      drop_d = out_q - OW'(resp_v);
      if (i_redirect_pc[1:0] == 2'b00) begin
        pc_d     = i_redirect_pc;
        halted_d = 1'b0;
      end else begin
        halted_d    = 1'b1;
        trap_pend_d = 1'b1;
        trap_pc_d   = i_redirect_pc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q        <= RESET_ADDR;
      out_q       <= '0;
      drop_q      <= '0;
      halted_q    <= 1'b0;
      trap_pend_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      halted_q    <= halted_d;
      trap_pend_q <= trap_pend_d;
    end
  end

  always_ff @(posedge i_clk) begin
    trap_pc_q <= trap_pc_d;
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .flush_i (i_redirect),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (count)
  );

  sync_fifo #(.WIDTH(ILEN), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .flush_i (i_redirect),
    .push_i  (accept),
    .wdata_i (pc_q),
    .pop_i   (tag_pop),
    .rdata_o (tag_pc),
    .empty_o (unused_tag_empty),
    .count_o (unused_tag_count)
  );

  assign o_imem_req  = req && !i_rst;
  assign o_imem_addr = i_rst ? RESET_ADDR : pc_q;
  assign o_valid     = valid && !i_rst;
  assign o_pc        = i_rst ? '0 : head.pc;
  assign o_inst      = i_rst ? '0 : head.inst;
  assign o_trap      = head.trap && !i_rst;
  assign o_count     = i_rst ? '0 : count;

endmodule
